// File: rtl/multi_edge_pulse_gen.sv
// Purpose: per-channel level-to-pulse converter with optional synchroniser, selectable
//          edge detect (rise/fall/both), stretchable pulse and sticky event flag.
// Latency: PULSE_SIG rises SYNC_STAGES+1 edges after LVL_SIG changes; no backpressure (free-running).
//
// Ports:
//   CLK         clock, all state on rising edge
//   RST         synchronous active-low reset
//   EN          global detect enable; 0 suppresses detects and aborts running pulses
//   LVL_SIG     per-channel level inputs
//   EDGE_MODE   per-channel mode, ch i = [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   PULSE_LEN   pulse length in cycles, 0 behaves as 1, captured only when a pulse loads
//   STICKY_CLR  per-channel sticky clear
//   PULSE_SIG   per-channel pulse outputs (decoded from counter registers)
//   STICKY      per-channel sticky event flags
//   ANY_PULSE   OR of all PULSE_SIG bits
module multi_edge_pulse_gen #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [NUM_CH-1:0]     LVL_SIG,
    input  logic [2*NUM_CH-1:0]   EDGE_MODE,
    input  logic [CNT_W-1:0]      PULSE_LEN,
    input  logic [NUM_CH-1:0]     STICKY_CLR,
    output logic [NUM_CH-1:0]     PULSE_SIG,
    output logic [NUM_CH-1:0]     STICKY,
    output logic                  ANY_PULSE
);

    // synchronised level and its one-cycle history
    logic [NUM_CH-1:0] lvl_s;
    logic [NUM_CH-1:0] lvl_p;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] det;

    // effective load value: a zero length still produces a one-cycle pulse
    logic [CNT_W-1:0]  load_len;

    logic [CNT_W-1:0]  cnt [NUM_CH];

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign lvl_s = LVL_SIG;
        end else begin : g_sync
            logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

            // The chain keeps running while EN=0 so re-enabling never
            // exposes a stale level as a false edge.
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= LVL_SIG;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign lvl_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // History flop also tracks regardless of EN. Reset leaves it at 0, so a
    // level already high at reset release is reported as one rising edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            lvl_p <= '0;
        end else begin
            lvl_p <= lvl_s;
        end
    end

    assign rise     = lvl_s & ~lvl_p;
    assign fall     = ~lvl_s & lvl_p;
    assign load_len = (PULSE_LEN == '0) ? CNT_W'(1) : PULSE_LEN;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign det[i] = EN & ((EDGE_MODE[2*i]   & rise[i]) |
                                  (EDGE_MODE[2*i+1] & fall[i]));

            // A detect during a running pulse reloads the counter, so the
            // pulse stretches without a gap instead of producing a second one.
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    cnt[i] <= '0;
                end else if (!EN) begin
                    cnt[i] <= '0;
                end else if (det[i]) begin
                    cnt[i] <= load_len;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end

            assign PULSE_SIG[i] = |cnt[i];
        end
    endgenerate

    // Set has priority over clear so an event in the clearing cycle is not lost.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            STICKY <= '0;
        end else begin
            STICKY <= det | (STICKY & ~STICKY_CLR);
        end
    end

    assign ANY_PULSE = |PULSE_SIG;

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Purpose: directed, self-checking bench for multi_edge_pulse_gen (2-stage sync build plus a 0-stage build).
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none; all stimulus is fixed-length, no open-ended waits.
module tb_multi_edge_pulse_gen;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [3:0] LVL_SIG;
    logic [7:0] EDGE_MODE;
    logic [3:0] PULSE_LEN;
    logic [3:0] STICKY_CLR;
    logic [3:0] PULSE_SIG;
    logic [3:0] STICKY;
    logic       ANY_PULSE;
    logic [3:0] pulse0;
    logic [3:0] sticky0;
    logic       any0;

    int total;
    int bad;

    multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(2), .CNT_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .LVL_SIG    (LVL_SIG),
        .EDGE_MODE  (EDGE_MODE),
        .PULSE_LEN  (PULSE_LEN),
        .STICKY_CLR (STICKY_CLR),
        .PULSE_SIG  (PULSE_SIG),
        .STICKY     (STICKY),
        .ANY_PULSE  (ANY_PULSE)
    );

    multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(0), .CNT_W(4)) dut0 (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .LVL_SIG    (LVL_SIG),
        .EDGE_MODE  (EDGE_MODE),
        .PULSE_LEN  (PULSE_LEN),
        .STICKY_CLR (STICKY_CLR),
        .PULSE_SIG  (pulse0),
        .STICKY     (sticky0),
        .ANY_PULSE  (any0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // n steps; PULSE_SIG[ch] and ANY_PULSE expected high on steps first..last
    task automatic run_expect(input int ch, input int n, input int first, input int last,
                              input string tag);
        logic e;
        for (int i = 1; i <= n; i++) begin
            step();
            e = (i >= first) && (i <= last);
            chk($sformatf("%s_p%0d", tag, i), {31'd0, PULSE_SIG[ch]}, {31'd0, e});
            chk($sformatf("%s_a%0d", tag, i), {31'd0, ANY_PULSE}, {31'd0, e});
        end
    endtask

    initial begin
        logic e;
        total      = 0;
        bad        = 0;
        RST        = 1'b0;
        EN         = 1'b1;
        LVL_SIG    = 4'b0000;
        EDGE_MODE  = 8'h00;
        PULSE_LEN  = 4'd1;
        STICKY_CLR = 4'b0000;

        // reset state
        steps(2);
        chk("rst_pulse",  {28'd0, PULSE_SIG}, 32'h0);
        chk("rst_sticky", {28'd0, STICKY},    32'h0);
        chk("rst_any",    {31'd0, ANY_PULSE}, 32'h0);
        RST = 1'b1;
        steps(3);
        chk("idle_pulse", {28'd0, PULSE_SIG}, 32'h0);

        // 1: ch0 rise, length 1, appears after the third sampling edge
        EDGE_MODE = {2'b00, 2'b00, 2'b00, 2'b01};
        PULSE_LEN = 4'd1;
        LVL_SIG[0] = 1'b1;
        step();
        chk("t1_e1", {28'd0, PULSE_SIG}, 32'h0);
        step();
        chk("t1_e2", {28'd0, PULSE_SIG}, 32'h0);
        step();
        chk("t1_e3_pulse",  {28'd0, PULSE_SIG}, 32'h1);
        chk("t1_e3_sticky", {28'd0, STICKY},    32'h1);
        chk("t1_e3_any",    {31'd0, ANY_PULSE}, 32'h1);
        step();
        chk("t1_e4_pulse",  {28'd0, PULSE_SIG}, 32'h0);
        chk("t1_e4_sticky", {28'd0, STICKY},    32'h1);
        chk("t1_e4_any",    {31'd0, ANY_PULSE}, 32'h0);

        // 2: ch1 both edges, length 3; then fall-only
        EDGE_MODE = {2'b00, 2'b00, 2'b11, 2'b01};
        PULSE_LEN = 4'd3;
        LVL_SIG[1] = 1'b1;
        run_expect(1, 6, 3, 5, "t2_rise");
        run_expect(1, 4, 0, -1, "t2_hold");
        LVL_SIG[1] = 1'b0;
        run_expect(1, 6, 3, 5, "t2_fall");
        chk("t2_sticky", {28'd0, STICKY}, 32'h3);
        EDGE_MODE = {2'b00, 2'b00, 2'b10, 2'b01};
        LVL_SIG[1] = 1'b1;
        run_expect(1, 6, 0, -1, "t2_f_rise");
        LVL_SIG[1] = 1'b0;
        run_expect(1, 6, 3, 5, "t2_f_fall");

        // 3: ch2 retrigger, toggles every 2 cycles x4, loads at 3,5,7,9 -> high 3..13
        EDGE_MODE = {2'b00, 2'b11, 2'b10, 2'b01};
        PULSE_LEN = 4'd5;
        for (int i = 0; i < 16; i++) begin
            if (i < 8 && (i % 2) == 0) LVL_SIG[2] = ~LVL_SIG[2];
            step();
            e = (i + 1 >= 3) && (i + 1 <= 13);
            chk($sformatf("t3_p%0d", i + 1), {31'd0, PULSE_SIG[2]}, {31'd0, e});
        end
        chk("t3_sticky", {28'd0, STICKY}, 32'h7);

        // 4: clear in the same cycle as a new detect -> set wins; clear alone -> 0
        LVL_SIG[0] = 1'b0;
        steps(3);
        LVL_SIG[0] = 1'b1;
        steps(2);
        STICKY_CLR = 4'b0001;
        step();
        STICKY_CLR = 4'b0000;
        chk("t4_setwins", {28'd0, STICKY},    32'h7);
        chk("t4_pulse",   {28'd0, PULSE_SIG}, 32'h1);
        STICKY_CLR = 4'b0001;
        step();
        STICKY_CLR = 4'b0000;
        chk("t4_clear", {28'd0, STICKY}, 32'h6);
        steps(6);
        chk("t4_drain", {28'd0, PULSE_SIG}, 32'h0);

        // 5: EN handling on ch3
        EDGE_MODE = {2'b01, 2'b11, 2'b10, 2'b01};
        EN = 1'b0;
        LVL_SIG[3] = 1'b1;
        steps(4);
        chk("t5_dis_pulse",  {28'd0, PULSE_SIG}, 32'h0);
        chk("t5_dis_sticky", {28'd0, STICKY},    32'h6);
        EN = 1'b1;
        run_expect(3, 4, 0, -1, "t5_reen");
        chk("t5_reen_sticky", {28'd0, STICKY}, 32'h6);
        PULSE_LEN = 4'd8;
        LVL_SIG[3] = 1'b0;
        steps(3);
        LVL_SIG[3] = 1'b1;
        steps(3);
        chk("t5_mid_on", {28'd0, PULSE_SIG}, 32'h8);
        PULSE_LEN = 4'd1;   // must not shorten the running pulse
        steps(2);
        chk("t5_mid_len", {28'd0, PULSE_SIG}, 32'h8);
        EN = 1'b0;
        step();
        chk("t5_abort_pulse",  {28'd0, PULSE_SIG}, 32'h0);
        chk("t5_abort_any",    {31'd0, ANY_PULSE}, 32'h0);
        chk("t5_abort_sticky", {28'd0, STICKY},    32'he);
        EN = 1'b1;

        // 6: reset mid pulse, PULSE_LEN=0, level high at release
        PULSE_LEN = 4'd8;
        LVL_SIG[3] = 1'b0;
        steps(3);
        LVL_SIG[3] = 1'b1;
        steps(3);
        chk("t6_on", {28'd0, PULSE_SIG}, 32'h8);
        steps(2);
        RST = 1'b0;
        step();
        chk("t6_rst_pulse",  {28'd0, PULSE_SIG}, 32'h0);
        chk("t6_rst_sticky", {28'd0, STICKY},    32'h0);
        chk("t6_rst_any",    {31'd0, ANY_PULSE}, 32'h0);
        PULSE_LEN = 4'd0;
        RST = 1'b1;
        // LVL_SIG = 1001 with ch0/ch3 in rise mode -> one rise event each
        steps(2);
        chk("t6_rel_e2", {28'd0, PULSE_SIG}, 32'h0);
        step();
        chk("t6_rel_e3",     {28'd0, PULSE_SIG}, 32'h9);
        chk("t6_rel_sticky", {28'd0, STICKY},    32'h9);
        step();
        chk("t6_len0_end", {28'd0, PULSE_SIG}, 32'h0);

        // 6b: unsynchronised build pulses on the first sampling edge
        PULSE_LEN = 4'd2;
        LVL_SIG[3] = 1'b0;
        steps(2);
        LVL_SIG[3] = 1'b1;
        step();
        chk("t6_s0_e1",   {28'd0, pulse0},    32'h8);
        chk("t6_s0_any",  {31'd0, any0},      32'h1);
        chk("t6_s2_e1",   {28'd0, PULSE_SIG}, 32'h0);
        step();
        chk("t6_s0_e2",   {28'd0, pulse0},    32'h8);
        step();
        chk("t6_s0_e3",   {28'd0, pulse0},    32'h0);
        chk("t6_s0_stk",  {28'd0, sticky0},   32'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
